// File: rtl/jts16_colmix_n_if.sv
// CPU palette bus for the colour mixer.
//   pal_cs    : palette chip select (write qualifier)
//   cpu_addr  : palette word address
//   cpu_dout  : CPU write data
//   dsn       : active-low byte strobes {upper, lower}
//   cpu_din   : palette read data, one clk after the address
// The CPU side uses the master modport; the mixer uses the slave modport.
interface jts16_colmix_n_if #(
   parameter int PALW = 11
) ();
   logic            pal_cs;
   logic [PALW-1:0] cpu_addr;
   logic [15:0]     cpu_dout;
   logic [1:0]      dsn;
   logic [15:0]     cpu_din;

   modport master (output pal_cs, cpu_addr, cpu_dout, dsn, input cpu_din);
   modport slave  (input pal_cs, cpu_addr, cpu_dout, dsn, output cpu_din);
endinterface

// File: rtl/jts16_colmix_n.sv
// Colour mixer: merges LAYERS tile layers and one sprite layer by priority,
// resolves sprite shadow/highlight effects, looks the winner up in palette
// RAM and outputs 5-bit RGB with blanking delayed to match.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   pxl_cen            : pixel enable, advances the 3-stage pipeline
//   video_en           : 0 forces RGB to 0
//   gfx_en             : per-layer enables, bit LAYERS gates the sprites
//   LHBL, LVBL         : active-low blanking in
//   cpu                : CPU palette bus (slave side)
//   tile_pxl           : per layer {priority, 11-bit palette index}
//   obj_pxl            : {priority, 6-bit palette, 4-bit colour}
//   red, green, blue   : colour out
//   LHBL_dly, LVBL_dly : blanking aligned with RGB
//   pal_clr            : palette clear in progress
module jts16_colmix_n #(
   parameter int LAYERS = 3,
   parameter int PALW   = 11,
   parameter int SHMODE = 0,
   parameter int CLR_EN = 1,
   parameter int OPW    = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pxl_cen,
   input  logic                   video_en,
   input  logic [LAYERS:0]        gfx_en,
   input  logic                   LHBL,
   input  logic                   LVBL,
   jts16_colmix_n_if.slave        cpu,
   input  logic [12*LAYERS-1:0]   tile_pxl,
   input  logic [OPW+9:0]         obj_pxl,
   output logic [4:0]             red,
   output logic [4:0]             green,
   output logic [4:0]             blue,
   output logic                   LHBL_dly,
   output logic                   LVBL_dly,
   output logic                   pal_clr
);
   localparam int PALN = 2**PALW;

   typedef enum logic {CLEAR, DONE} clr_state_t;

   typedef struct packed {
      logic        sel;   // 1 = sprite palette (upper half)
      logic [10:0] idx;
      logic        opq;
      logic        sh;
      logic        hl;
   } cand_t;

   // ---------------- S1: gated layer candidates ----------------
   logic [LAYERS-1:0][11:0] tile_s1;
   logic [OPW+9:0]          obj_s1;

   // NOTE: every clocked process uses non-blocking assignments so all
   // registers sample the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         tile_s1 <= '0;
         obj_s1  <= '0;
      end else if (pxl_cen) begin
         for (int k = 0; k < LAYERS; k++)
            tile_s1[k] <= {tile_pxl[12*k+3 +: 9], tile_pxl[12*k +: 3] & {3{gfx_en[k]}}};
         obj_s1 <= {obj_pxl[OPW+9:4], obj_pxl[3:0] & {4{gfx_en[LAYERS]}}};
      end
   end

   // ---------------- priority resolution ----------------
   logic  spr_opq, spr_eff, spr_hl;
   cand_t [LAYERS-1:0] cand;
   cand_t pick;

   assign spr_opq = obj_s1[3:0] != 4'd0;
   assign spr_eff = obj_s1[9:4] == 6'h3F;
   assign spr_hl  = (SHMODE != 0) && obj_s1[3];

   // NOTE: each combinational output gets a default first, so no path
   // through the block can leave it unassigned and infer a latch.
   always_comb begin
      for (int k = 0; k < LAYERS; k++) begin
         logic win;
         cand[k] = '0;
         win = spr_opq && (int'(obj_s1[OPW+9:10]) >= LAYERS - k) && !tile_s1[k][11];
         if (win && !spr_eff) begin
            cand[k].sel = 1'b1;
            cand[k].idx = {1'b0, obj_s1[9:0]};
            cand[k].opq = 1'b1;
         end else begin
            // An effect sprite keeps the tile colour and only marks it.
            cand[k].idx = tile_s1[k][10:0];
            cand[k].opq = tile_s1[k][2:0] != 3'd0;
            cand[k].sh  = win && spr_eff && !spr_hl;
            cand[k].hl  = win && spr_eff && spr_hl;
         end
      end
   end

   // Bottom layer is the fallback; walking upward lets the topmost opaque
   // candidate overwrite it.
   always_comb begin
      pick = cand[LAYERS-1];
      for (int k = LAYERS-2; k >= 0; k--)
         if (cand[k].opq) pick = cand[k];
   end

   logic pick_unused;
   assign pick_unused = ^pick;

   // ---------------- S2: palette address and effect flags ----------------
   logic [PALW-1:0] addr_s2;
   logic            sh_s2, hl_s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_s2 <= '0;
         sh_s2   <= 1'b0;
         hl_s2   <= 1'b0;
      end else if (pxl_cen) begin
         addr_s2 <= {pick.sel, pick.idx[PALW-2:0]};
         sh_s2   <= pick.sh;
         hl_s2   <= pick.hl;
      end
   end

   // ---------------- clear engine ----------------
   clr_state_t      state, state_nx;
   logic [PALW-1:0] clr_addr, clr_addr_nx;
   logic            clr_wr;
   logic [1:0]      cpu_we;

   assign cpu_we = ~cpu.dsn & {2{cpu.pal_cs}};

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= (CLR_EN != 0) ? CLEAR : DONE;
         clr_addr <= '0;
      end else begin
         state    <= state_nx;
         clr_addr <= clr_addr_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      clr_addr_nx = clr_addr;
      clr_wr      = 1'b0;
      case (state)
         CLEAR: if (cpu_we == 2'b00) begin   // a CPU write takes the port
            clr_wr      = 1'b1;
            clr_addr_nx = clr_addr + PALW'(1);
            if (&clr_addr) state_nx = DONE;
         end
         default: ;
      endcase
   end

   assign pal_clr = state == CLEAR;

   // ---------------- palette RAM ----------------
   logic [15:0]     mem [0:PALN-1];
   logic [1:0]      we0;
   logic [PALW-1:0] a0;
   logic [15:0]     d0, vid_q;

   assign we0 = clr_wr ? 2'b11    : cpu_we;
   assign a0  = clr_wr ? clr_addr : cpu.cpu_addr;
   assign d0  = clr_wr ? 16'd0    : cpu.cpu_dout;

   // NOTE: the RAM array and its read registers have no reset; clearing the
   // contents is the clear engine's job, not the reset network's.
   always_ff @(posedge clk) begin
      if (we0[0]) mem[a0][7:0]  <= d0[7:0];
      if (we0[1]) mem[a0][15:8] <= d0[15:8];
      cpu.cpu_din <= mem[a0];
   end

   always_ff @(posedge clk) vid_q <= mem[addr_s2];

   // ---------------- S3: effects and output ----------------
   function automatic logic [4:0] shade(input logic [4:0] c, input logic sh,
                                        input logic hl, input logic dark);
      if (hl)
         shade = c + ((5'd31 - c) >> 1);
      else if (sh && dark)
         shade = c >> 1;
      else
         shade = c;
   endfunction

   logic [2:0] hb_pipe, vb_pipe;

   always_ff @(posedge clk) begin
      if (rst) begin
         red     <= '0;
         green   <= '0;
         blue    <= '0;
         hb_pipe <= '0;
         vb_pipe <= '0;
      end else if (pxl_cen) begin
         hb_pipe <= {hb_pipe[1:0], LHBL};
         vb_pipe <= {vb_pipe[1:0], LVBL};
         if (!video_en || pal_clr) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
         end else begin
            red   <= shade({vid_q[3:0],  vid_q[12]}, sh_s2, hl_s2, vid_q[15]);
            green <= shade({vid_q[7:4],  vid_q[13]}, sh_s2, hl_s2, vid_q[15]);
            blue  <= shade({vid_q[11:8], vid_q[14]}, sh_s2, hl_s2, vid_q[15]);
         end
      end
   end

   assign LHBL_dly = hb_pipe[2];
   assign LVBL_dly = vb_pipe[2];
endmodule

// File: tb/tb_jts16_colmix_n.sv
// Bench for jts16_colmix_n (LAYERS=3, PALW=11, SHMODE=1, CLR_EN=1).
// A behavioural pixel model, evaluated on every pixel tick, predicts RGB and
// blanking three ticks later; directed cases pin the model with literals.
module tb_jts16_colmix_n;
   localparam int LAYERS = 3;
   localparam int PALW   = 11;
   localparam int SHMODE = 1;

   logic        clk = 1'b0, rst = 1'b1, pxl_cen = 1'b0, video_en = 1'b1;
   logic [3:0]  gfx_en = 4'hF;
   logic        LHBL = 1'b1, LVBL = 1'b1;
   logic [35:0] tile_pxl = '0;
   logic [11:0] obj_pxl = '0;
   logic [4:0]  red, green, blue;
   logic        LHBL_dly, LVBL_dly, pal_clr;

   jts16_colmix_n_if #(.PALW(PALW)) cpu_bus ();

   jts16_colmix_n #(.LAYERS(LAYERS), .PALW(PALW), .SHMODE(SHMODE), .CLR_EN(1), .OPW(2)) dut (
      .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .video_en(video_en), .gfx_en(gfx_en),
      .LHBL(LHBL), .LVBL(LVBL), .cpu(cpu_bus), .tile_pxl(tile_pxl), .obj_pxl(obj_pxl),
      .red(red), .green(green), .blue(blue), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly),
      .pal_clr(pal_clr)
   );

   always #5 clk = ~clk;

   int cen_cnt = 0;
   always @(negedge clk) begin
      cen_cnt = (cen_cnt + 1) % 4;
      pxl_cen = (cen_cnt == 0);
   end

   int n_checks = 0, n_fail = 0;
   logic [15:0] pal_m [0:2047];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Returns {LHBL, LVBL, R, G, B} for one input pixel.
   function automatic logic [16:0] model_px(input logic [35:0] tp, input logic [11:0] op,
                                            input logic [3:0] ge, input logic hb, input logic vb);
      int scol, spal, spri, idx, addr, r, g, b;
      bit tpri, spr_on, opaque, shadow, hilite;
      logic [15:0] p;
      scol = ge[3] ? int'(op[3:0]) : 0;
      spal = int'(op[9:4]);
      spri = int'(op[11:10]);
      addr = 0; shadow = 0; hilite = 0; opaque = 0;
      for (int k = 0; k < 3; k++) begin
         idx  = int'(tp[12*k +: 11]);
         tpri = tp[12*k+11];
         if (!ge[k]) idx = idx - (idx % 8);
         spr_on = (scol != 0) && (spri >= 3 - k) && !tpri;
         shadow = 0; hilite = 0;
         if (spr_on && spal != 63) begin
            addr = 1024 + spal*16 + scol;
            opaque = 1;
         end else begin
            addr = idx % 1024;
            opaque = (idx % 8) != 0;
            if (spr_on) begin
               if (SHMODE != 0 && scol >= 8) hilite = 1;
               else shadow = 1;
            end
         end
         if (opaque) break;
      end
      p = pal_m[addr];
      r = int'(p[3:0])*2  + int'(p[12]);
      g = int'(p[7:4])*2  + int'(p[13]);
      b = int'(p[11:8])*2 + int'(p[14]);
      if (hilite) begin
         r = r + (31 - r)/2; g = g + (31 - g)/2; b = b + (31 - b)/2;
      end else if (shadow && p[15]) begin
         r = r/2; g = g/2; b = b/2;
      end
      return {hb, vb, 5'(r), 5'(g), 5'(b)};
   endfunction

   // ---------------- continuous compare against the model ----------------
   bit          chk_en = 0, pending = 0, exp_ready = 0;
   int          hist_n = 0;
   logic [16:0] hist [3];
   logic [16:0] exp_px;

   always @(posedge clk) begin
      if (!chk_en) begin
         hist_n = 0;
         exp_ready = 0;
      end else if (pxl_cen) begin
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = model_px(tile_pxl, obj_pxl, gfx_en, LHBL, LVBL);
         if (hist_n < 3) hist_n++;
         exp_ready = (hist_n == 3);
         exp_px = hist[2];
         if (!video_en) exp_px[14:0] = '0;
         pending = 1;
      end
   end

   always @(negedge clk) begin
      if (pending) begin
         pending = 0;
         if (exp_ready) begin
            check("model_rgb",  {17'd0, red, green, blue}, {17'd0, exp_px[14:0]});
            check("model_lhbl", {31'd0, LHBL_dly}, {31'd0, exp_px[16]});
            check("model_lvbl", {31'd0, LVBL_dly}, {31'd0, exp_px[15]});
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic next_px();
      @(posedge clk iff pxl_cen);
      @(negedge clk);
   endtask

   task automatic cpu_write(input logic [10:0] a, input logic [15:0] d, input logic [1:0] ds);
      cpu_bus.pal_cs   = 1'b1;
      cpu_bus.cpu_addr = a;
      cpu_bus.cpu_dout = d;
      cpu_bus.dsn      = ds;
      @(negedge clk);
      cpu_bus.pal_cs = 1'b0;
      cpu_bus.dsn    = 2'b11;
      if (!ds[0]) pal_m[a][7:0]  = d[7:0];
      if (!ds[1]) pal_m[a][15:8] = d[15:8];
   endtask

   task automatic reset_and_clear(input bit collide, output int n);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 5000 && pal_clr; i++) begin
         n++;
         if (collide && i == 500) begin
            cpu_bus.pal_cs = 1'b1; cpu_bus.cpu_addr = 11'd100;
            cpu_bus.cpu_dout = 16'hA5C3; cpu_bus.dsn = 2'b00;
         end else begin
            cpu_bus.pal_cs = 1'b0; cpu_bus.dsn = 2'b11;
         end
         if (i == 1000) check("rgb_during_clear", {17'd0, red, green, blue}, 32'd0);
         @(negedge clk);
      end
      cpu_bus.pal_cs = 1'b0;
      cpu_bus.dsn = 2'b11;
      for (int a = 0; a < 2048; a++) pal_m[a] = 16'h0000;
      if (collide) pal_m[100] = 16'hA5C3;
   endtask

   task automatic expect_rgb(input string name, input logic [4:0] r, input logic [4:0] g,
                             input logic [4:0] b);
      check(name, {17'd0, red, green, blue}, {17'd0, r, g, b});
   endtask

   int n_clr;

   initial begin
      cpu_bus.pal_cs = 1'b0; cpu_bus.cpu_addr = '0; cpu_bus.cpu_dout = '0; cpu_bus.dsn = 2'b11;
      tile_pxl = {12'd0, 12'd0, 12'd5};   // opaque input while the clear runs

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_rgb",     {17'd0, red, green, blue}, 32'd0);
      check("rst_lhbl",    {31'd0, LHBL_dly}, 32'd0);
      check("rst_lvbl",    {31'd0, LVBL_dly}, 32'd0);
      check("rst_pal_clr", {31'd0, pal_clr}, 32'd1);

      reset_and_clear(1'b0, n_clr);
      check("clear_cycles", n_clr, 2048);

      reset_and_clear(1'b1, n_clr);
      check("clear_cycles_collide", n_clr, 2049);
      for (int a = 0; a < 2048; a++) begin
         cpu_bus.cpu_addr = 11'(a);
         @(negedge clk);
         check("readback", {16'd0, cpu_bus.cpu_din}, {16'd0, pal_m[a]});
      end

      // Random palette, some byte-lane writes, then the directed entries
      for (int a = 0; a < 2048; a++) cpu_write(11'(a), 16'($urandom), 2'b00);
      for (int i = 0; i < 32; i++)
         cpu_write(11'($urandom_range(0, 2047)), 16'($urandom), 2'($urandom_range(1, 2)));
      cpu_write(11'h005, 16'h001F, 2'b00);
      cpu_write(11'h405, 16'h0F00, 2'b00);
      cpu_write(11'h007, 16'h801F, 2'b00);
      cpu_write(11'h009, 16'h0008, 2'b00);
      cpu_bus.cpu_addr = 11'h405;
      @(negedge clk);
      check("readback_405", {16'd0, cpu_bus.cpu_din}, 32'h0F00);

      chk_en = 1;
      next_px();

      // Layer 0 only
      tile_pxl = {12'd0, 12'd0, 12'd5}; obj_pxl = '0;
      repeat (3) next_px();
      expect_rgb("layer0_only", 5'd30, 5'd2, 5'd0);

      // Sprite over layer 0, then tile priority set
      obj_pxl = {2'b11, 10'h005};
      repeat (3) next_px();
      expect_rgb("sprite_wins", 5'd0, 5'd0, 5'd30);
      tile_pxl = {12'd0, 12'd0, 12'h805};
      repeat (3) next_px();
      expect_rgb("tile_prio_wins", 5'd30, 5'd2, 5'd0);

      // Shadow then highlight effect sprites
      tile_pxl = {12'd0, 12'd0, 12'd7}; obj_pxl = {2'b11, 10'h3F3};
      repeat (3) next_px();
      expect_rgb("shadow", 5'd15, 5'd1, 5'd0);
      tile_pxl = {12'd0, 12'd0, 12'd9}; obj_pxl = {2'b11, 10'h3F9};
      repeat (3) next_px();
      expect_rgb("highlight", 5'd23, 5'd15, 5'd15);

      // Disabled layer 0 shows layer 1; LHBL delay
      tile_pxl = {12'd0, 12'd9, 12'd5}; obj_pxl = '0; gfx_en = 4'b1110; LHBL = 1'b0;
      repeat (2) next_px();
      check("lhbl_not_yet", {31'd0, LHBL_dly}, 32'd1);
      next_px();
      check("lhbl_3_ticks", {31'd0, LHBL_dly}, 32'd0);
      expect_rgb("gfx_en0_off", 5'd16, 5'd0, 5'd0);
      gfx_en = 4'hF; LHBL = 1'b1;
      video_en = 1'b0;
      repeat (3) next_px();
      expect_rgb("video_off", 5'd0, 5'd0, 5'd0);
      video_en = 1'b1;

      // Random pixels
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 3; k++) begin
            logic [11:0] t;
            t = 12'($urandom);
            if ($urandom_range(0, 9) < 4) t[2:0] = 3'd0;
            tile_pxl[12*k +: 12] = t;
         end
         obj_pxl = 12'($urandom);
         if ($urandom_range(0, 3) == 0) obj_pxl[9:4] = 6'h3F;
         if ($urandom_range(0, 9) < 3) obj_pxl[3:0] = 4'd0;
         for (int k = 0; k < 4; k++) gfx_en[k] = $urandom_range(0, 6) != 0;
         LHBL = 1'($urandom);
         LVBL = 1'($urandom);
         video_en = $urandom_range(0, 9) != 0;
         next_px();
      end
      repeat (3) next_px();
      chk_en = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end
endmodule
